read_resp_engine: RTL and testbench
===================================

# read_resp_engine

Receive-side counterpart of the read-request engine: consumes CCI-P channel-0 read responses, decodes control-polling lines into the control-response handshake, and tracks run-data responses with a count, completion flag and optional checksum. Sits between the MPF c0 RX path and the AFU state machine, sharing `afu_state` and the `READ_CTRL_MDATA`/`READ_RUN_MDATA` tags from `interface_debug`.

## Interface
Parameters:
- `CSUM_W`, 32, checksum accumulator width (16 or 32).

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `afu_state`  in  e_afu_state  current AFU state
- `rx_valid`  in  1  read response valid (c0 RdLine response)
- `rx_mdata`  in  t_cci_mdata  response tag
- `rx_data`  in  512  response cache line
- `ctrl_resp`  ctrl_resp_if.from_module  `valid`, `ack`, `code`[31:0], `rd_addr` t_cci_clAddr, `num_cls` t_uint32
- `run_rsp_count`  out  32  run responses received
- `run_rsp_done`  out  1  all expected run responses received
- `run_checksum`  out  CSUM_W  running checksum
- `err_unexpected`  out  1  sticky: unknown tag or tag/state mismatch
- `err_overrun`  out  1  sticky: run response beyond expected count

## Operation
- Control line layout: `code` = `rx_data[31:0]`, `num_cls` = `rx_data[63:32]`, `rd_addr` = `rx_data[64 +: 42]`; other bits ignored.
- Stage 1 registers `rx_valid`, `rx_mdata`, decoded fields, folded data, and `afu_state` sampled the same cycle. All decisions use the stage-1 state copy.
- Control path (stage-1 tag `READ_CTRL_MDATA`, state `AFU_CTRL`): pulse `ctrl_resp.ack` one cycle; pulse `ctrl_resp.valid` the same cycle only if `code != 0`. `code`/`rd_addr`/`num_cls` update with every ack and hold otherwise.
- On accepted `CONTROL_START_RUN`: `expected` ← `num_cls + 1` (33-bit, no wrap; the request engine covers `start..start+num_cls` inclusive); clear count, checksum, `run_rsp_done`, `err_overrun`.
- Run path (tag `READ_RUN_MDATA`, state `AFU_RUN`): if `count < expected`, count+1 and checksum += fold; `run_rsp_done` sets when count reaches `expected` and holds until next START. Otherwise set `err_overrun`; count and checksum unchanged.
- Fold: XOR of the 16 32-bit words of `rx_data` (for `CSUM_W=16`, upper and lower halves XORed). Accumulation is modulo 2^CSUM_W.
- Ctrl tag outside `AFU_CTRL`, run tag outside `AFU_RUN`, or any other tag: response dropped, `err_unexpected` set. Errors clear only on reset.
- No backpressure: one response per cycle accepted unconditionally.

## Timing
- Reset: all outputs and internal registers 0, including `expected`. `run_rsp_done` stays 0 until a START is accepted.
- `ctrl_resp.valid`/`ack` rise 2 cycles after the `rx_valid` cycle (stage 1 + output register). Fields are valid in the same cycle.
- Count, checksum, done and error outputs update 2 cycles after `rx_valid`.
- Back-to-back run responses every cycle are counted without loss. Throughput is 1 response per clock.
- A response arriving in the same cycle `afu_state` changes is classified by the state sampled with it.
- START accepted while a run is in flight clears the counters. A run response from that same stage-1 cycle cannot coexist, because the states differ.
- Asynchronous reset mid-run clears everything immediately. No partial pulse survives reset release.

## Configuration
- `READ_RESP_CHECKSUM_EN` defined: fold and accumulator present as above.
- Not defined: `run_checksum` tied to 0, fold logic removed. Count, done and errors are unaffected.

## Test plan
- Reset, then `AFU_CTRL`: ctrl tag with `code=0` -> `ack` pulse at +2, `valid` stays 0.
- Ctrl tag, `code=CONTROL_START_RUN`, `num_cls=3`, `rd_addr=0x1000` -> `valid`+`ack` one cycle, `rd_addr=0x1000`, `num_cls=3`, count=0.
- Then `AFU_RUN`, 4 back-to-back run responses with all-zero lines except word0 = 1,2,3,4 -> count=4, `run_rsp_done`=1 at +2 after 4th, checksum=10 (0 without macro).
- 5th run response -> `err_overrun`=1, count stays 4, checksum stays 10.
- Run tag while in `AFU_CTRL`, and tag 0x7FFF in any state -> `err_unexpected`=1, no ack, count unchanged.
- Assert `reset_n`=0 mid-run after 2 responses -> all outputs 0 immediately. New START with `num_cls=0` then 1 response -> done=1, count=1.

Source files
------------

// File: rtl/read_resp_engine_if.sv
// Shared AFU/CCI-P types and tags, plus the control-response interface driven by read_resp_engine.
package read_resp_pkg;
    typedef enum logic [1:0] {
        AFU_IDLE = 2'd0,
        AFU_CTRL = 2'd1,
        AFU_RUN  = 2'd2,
        AFU_DONE = 2'd3
    } e_afu_state;

    typedef logic [15:0] t_cci_mdata;
    typedef logic [41:0] t_cci_clAddr;
    typedef logic [31:0] t_uint32;

    localparam t_cci_mdata  READ_CTRL_MDATA   = 16'h0001;
    localparam t_cci_mdata  READ_RUN_MDATA    = 16'h0002;
    localparam logic [31:0] CONTROL_START_RUN = 32'h0000_0001;
endpackage

interface ctrl_resp_if;
    import read_resp_pkg::*;

    logic        valid;
    logic        ack;
    logic [31:0] code;
    t_cci_clAddr rd_addr;
    t_uint32     num_cls;

    modport from_module (output valid, ack, code, rd_addr, num_cls);
    modport to_module   (input  valid, ack, code, rd_addr, num_cls);
endinterface

// File: rtl/read_resp_engine.sv
// CCI-P c0 read-response decoder: control-line handshake plus run-response count/done/checksum.
// Optional checksum accumulator enabled by defining READ_RESP_CHECKSUM_EN.
module read_resp_engine
    import read_resp_pkg::*;
#(
    parameter int CSUM_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  e_afu_state          afu_state,
    input  logic                rx_valid,
    input  t_cci_mdata          rx_mdata,
    input  logic [511:0]        rx_data,
    ctrl_resp_if.from_module    ctrl_resp,
    output logic [31:0]         run_rsp_count,
    output logic                run_rsp_done,
    output logic [CSUM_W-1:0]   run_checksum,
    output logic                err_unexpected,
    output logic                err_overrun
);

    logic        vld_p1;
    t_cci_mdata  mdata_p1;
    e_afu_state  state_p1;
    logic [31:0] code_p1;
    t_uint32     num_cls_p1;
    t_cci_clAddr rd_addr_p1;

    logic        ack_p2;
    logic        valid_p2;
    logic [31:0] code_p2;
    t_uint32     num_cls_p2;
    t_cci_clAddr rd_addr_p2;
    logic [32:0] expected_p2;
    logic [32:0] count_p2;
    logic        done_p2;
    logic        err_unexp_p2;
    logic        err_over_p2;

    logic        ctrl_hit;
    logic        run_hit;
    logic        start_hit;
    logic        run_accept;
    logic        stray;
    logic [32:0] count_inc;

    // Stage 1: capture response, decoded control fields and the state it arrived under
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            mdata_p1   <= '0;
            state_p1   <= AFU_IDLE;
            code_p1    <= '0;
            num_cls_p1 <= '0;
            rd_addr_p1 <= '0;
        end else begin
            vld_p1     <= rx_valid;
            mdata_p1   <= rx_mdata;
            state_p1   <= afu_state;
            code_p1    <= rx_data[31:0];
            num_cls_p1 <= rx_data[63:32];
            rd_addr_p1 <= rx_data[64 +: 42];
        end
    end

    assign ctrl_hit   = vld_p1 && (mdata_p1 == READ_CTRL_MDATA) && (state_p1 == AFU_CTRL);
    assign run_hit    = vld_p1 && (mdata_p1 == READ_RUN_MDATA)  && (state_p1 == AFU_RUN);
    assign stray      = vld_p1 && !ctrl_hit && !run_hit;
    assign start_hit  = ctrl_hit && (code_p1 == CONTROL_START_RUN);
    assign run_accept = run_hit && (count_p2 < expected_p2);
    assign count_inc  = count_p2 + 33'd1;

    // Stage 2: output registers for handshake, run tracking and sticky errors
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_p2       <= 1'b0;
            valid_p2     <= 1'b0;
            code_p2      <= '0;
            num_cls_p2   <= '0;
            rd_addr_p2   <= '0;
            expected_p2  <= '0;
            count_p2     <= '0;
            done_p2      <= 1'b0;
            err_unexp_p2 <= 1'b0;
            err_over_p2  <= 1'b0;
        end else begin
            ack_p2   <= ctrl_hit;
            valid_p2 <= ctrl_hit && (code_p1 != '0);
            if (ctrl_hit) begin
                code_p2    <= code_p1;
                num_cls_p2 <= num_cls_p1;
                rd_addr_p2 <= rd_addr_p1;
            end
            // 33-bit expected so num_cls = 2^32-1 still yields a reachable target
            if (start_hit) begin
                expected_p2 <= {1'b0, num_cls_p1} + 33'd1;
                count_p2    <= '0;
                done_p2     <= 1'b0;
                err_over_p2 <= 1'b0;
            end else if (run_accept) begin
                count_p2 <= count_inc;
                if (count_inc == expected_p2) begin
                    done_p2 <= 1'b1;
                end
            end else if (run_hit) begin
                err_over_p2 <= 1'b1;
            end
            if (stray) begin
                err_unexp_p2 <= 1'b1;
            end
        end
    end

`ifdef READ_RESP_CHECKSUM_EN
    logic [CSUM_W-1:0] fold_p1;
    logic [CSUM_W-1:0] csum_p2;

    function automatic logic [CSUM_W-1:0] fold_line(input logic [511:0] line);
        logic [31:0] acc;
        logic [31:0] half;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ line[32*i +: 32];
        end
        half = {16'h0000, acc[31:16] ^ acc[15:0]};
        return (CSUM_W == 16) ? half[CSUM_W-1:0] : acc[CSUM_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fold_p1 <= '0;
            csum_p2 <= '0;
        end else begin
            fold_p1 <= fold_line(rx_data);
            if (start_hit) begin
                csum_p2 <= '0;
            end else if (run_accept) begin
                csum_p2 <= csum_p2 + fold_p1;
            end
        end
    end

    assign run_checksum = csum_p2;
`else
    // Only the control fields of the line are consumed without the checksum
    logic unused_line_bits;
    assign unused_line_bits = ^rx_data[511:106];
    assign run_checksum     = '0;
`endif

    assign ctrl_resp.ack     = ack_p2;
    assign ctrl_resp.valid   = valid_p2;
    assign ctrl_resp.code    = code_p2;
    assign ctrl_resp.num_cls = num_cls_p2;
    assign ctrl_resp.rd_addr = rd_addr_p2;

    assign run_rsp_count  = count_p2[31:0];
    assign run_rsp_done   = done_p2;
    assign err_unexpected = err_unexp_p2;
    assign err_overrun    = err_over_p2;

endmodule

// File: tb/tb_read_resp_engine.sv
// Bench for read_resp_engine: directed vector table, reset corner sequences and randomized traffic vs. a behavioural model.
module tb_read_resp_engine;
    import read_resp_pkg::*;

    localparam int CSUM_W = 32;
`ifdef READ_RESP_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    e_afu_state        afu_state;
    logic              rx_valid;
    t_cci_mdata        rx_mdata;
    logic [511:0]      rx_data;
    logic [31:0]       run_rsp_count;
    logic              run_rsp_done;
    logic [CSUM_W-1:0] run_checksum;
    logic              err_unexpected;
    logic              err_overrun;

    ctrl_resp_if ctrl_bus ();

    read_resp_engine #(.CSUM_W(CSUM_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .afu_state      (afu_state),
        .rx_valid       (rx_valid),
        .rx_mdata       (rx_mdata),
        .rx_data        (rx_data),
        .ctrl_resp      (ctrl_bus),
        .run_rsp_count  (run_rsp_count),
        .run_rsp_done   (run_rsp_done),
        .run_checksum   (run_checksum),
        .err_unexpected (err_unexpected),
        .err_overrun    (err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              ack;
        logic              valid;
        logic [31:0]       code;
        logic [41:0]       addr;
        logic [31:0]       num;
        logic [31:0]       count;
        logic              done;
        logic [CSUM_W-1:0] csum;
        logic              eu;
        logic              eo;
    } snap_t;

    typedef struct {
        e_afu_state  st;
        t_cci_mdata  tag;
        logic        vld;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [41:0] addr;
        logic        ack;
        logic        valid;
        logic [31:0] count;
        logic        done;
        logic [31:0] csum;
        logic        eu;
        logic        eo;
        logic [31:0] num_out;
        logic [41:0] addr_out;
    } vec_t;

    typedef struct {
        snap_t s;
        bit    has_vec;
        vec_t  v;
        int    idx;
    } pend_t;

    int    n_pass = 0;
    int    n_total = 0;
    pend_t pq[$];
    vec_t  vecs[11];
    vec_t  nov;

    // Reference model state, kept as plain integers
    logic [31:0] m_code;
    logic [41:0] m_addr;
    logic [31:0] m_num;
    longint      m_expected;
    longint      m_count;
    longint      m_csum;
    bit          m_done;
    bit          m_eu;
    bit          m_eo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic snap_t zero_snap();
        snap_t z;
        z.ack = 1'b0; z.valid = 1'b0; z.code = '0; z.addr = '0; z.num = '0;
        z.count = '0; z.done = 1'b0; z.csum = '0; z.eu = 1'b0; z.eo = 1'b0;
        return z;
    endfunction

    task automatic model_reset();
        pend_t p;
        m_code = '0; m_addr = '0; m_num = '0;
        m_expected = 0; m_count = 0; m_csum = 0;
        m_done = 1'b0; m_eu = 1'b0; m_eo = 1'b0;
        pq.delete();
        p.s = zero_snap(); p.has_vec = 1'b0; p.v = nov; p.idx = 0;
        pq.push_back(p);
        pq.push_back(p);
    endtask

    task automatic model_step(input logic vld, input e_afu_state st, input t_cci_mdata tag,
                              input logic [511:0] d, output snap_t s);
        logic [31:0] f;
        logic        ack;
        logic        valid;
        f = '0;
        ack = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) f = f ^ d[i*32 +: 32];
        if (vld) begin
            if (tag == READ_CTRL_MDATA && st == AFU_CTRL) begin
                ack = 1'b1;
                valid = (d[31:0] != 32'd0);
                m_code = d[31:0];
                m_num = d[63:32];
                m_addr = d[105:64];
                if (m_code == CONTROL_START_RUN) begin
                    m_expected = longint'({32'h0, m_num}) + 1;
                    m_count = 0; m_csum = 0; m_done = 1'b0; m_eo = 1'b0;
                end
            end else if (tag == READ_RUN_MDATA && st == AFU_RUN) begin
                if (m_count < m_expected) begin
                    m_count = m_count + 1;
                    m_csum = (m_csum + longint'({32'h0, f})) % (longint'(1) << CSUM_W);
                    if (m_count == m_expected) m_done = 1'b1;
                end else begin
                    m_eo = 1'b1;
                end
            end else begin
                m_eu = 1'b1;
            end
        end
        s.ack = ack; s.valid = valid; s.code = m_code; s.addr = m_addr; s.num = m_num;
        s.count = 32'(m_count); s.done = m_done;
        s.csum = CSUM_ON ? CSUM_W'(m_csum) : '0;
        s.eu = m_eu; s.eo = m_eo;
    endtask

    task automatic compare(input pend_t p);
        chk("ack", 64'(ctrl_bus.ack), 64'(p.s.ack));
        chk("valid", 64'(ctrl_bus.valid), 64'(p.s.valid));
        chk("code", 64'(ctrl_bus.code), 64'(p.s.code));
        chk("rd_addr", 64'(ctrl_bus.rd_addr), 64'(p.s.addr));
        chk("num_cls", 64'(ctrl_bus.num_cls), 64'(p.s.num));
        chk("count", 64'(run_rsp_count), 64'(p.s.count));
        chk("done", 64'(run_rsp_done), 64'(p.s.done));
        chk("checksum", 64'(run_checksum), 64'(p.s.csum));
        chk("err_unexpected", 64'(err_unexpected), 64'(p.s.eu));
        chk("err_overrun", 64'(err_overrun), 64'(p.s.eo));
        if (p.has_vec) begin
            chk($sformatf("vec%0d_ack", p.idx), 64'(ctrl_bus.ack), 64'(p.v.ack));
            chk($sformatf("vec%0d_valid", p.idx), 64'(ctrl_bus.valid), 64'(p.v.valid));
            chk($sformatf("vec%0d_count", p.idx), 64'(run_rsp_count), 64'(p.v.count));
            chk($sformatf("vec%0d_done", p.idx), 64'(run_rsp_done), 64'(p.v.done));
            chk($sformatf("vec%0d_csum", p.idx), 64'(run_checksum), 64'(p.v.csum));
            chk($sformatf("vec%0d_err_unexp", p.idx), 64'(err_unexpected), 64'(p.v.eu));
            chk($sformatf("vec%0d_err_over", p.idx), 64'(err_overrun), 64'(p.v.eo));
            chk($sformatf("vec%0d_num_cls", p.idx), 64'(ctrl_bus.num_cls), 64'(p.v.num_out));
            chk($sformatf("vec%0d_rd_addr", p.idx), 64'(ctrl_bus.rd_addr), 64'(p.v.addr_out));
        end
    endtask

    // One response slot per clock; outputs checked against the slot two clocks earlier
    task automatic tick(input logic vld, input e_afu_state st, input t_cci_mdata tag,
                        input logic [511:0] d, input bit has_vec, input vec_t v, input int idx);
        pend_t p;
        rx_valid = vld; afu_state = st; rx_mdata = tag; rx_data = d;
        model_step(vld, st, tag, d, p.s);
        p.has_vec = has_vec; p.v = v; p.idx = idx;
        pq.push_back(p);
        @(negedge clk);
        if (pq.size() > 2) compare(pq.pop_front());
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] line(input logic [31:0] w0, input logic [31:0] w1, input logic [41:0] addr);
        logic [511:0] d;
        d = '0;
        d[31:0] = w0;
        d[63:32] = w1;
        d[105:64] = addr;
        return d;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, AFU_IDLE, 16'h0, '0, 1'b0, nov, 0);
    endtask

    task automatic send(input e_afu_state st, input t_cci_mdata tag, input logic [31:0] w0,
                        input logic [31:0] w1, input logic [41:0] addr);
        tick(1'b1, st, tag, line(w0, w1, addr), 1'b0, nov, 0);
    endtask

    task automatic reset_check(input string name);
        reset_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk({name, "_ack"}, 64'(ctrl_bus.ack), 64'd0);
        chk({name, "_valid"}, 64'(ctrl_bus.valid), 64'd0);
        chk({name, "_code"}, 64'(ctrl_bus.code), 64'd0);
        chk({name, "_rd_addr"}, 64'(ctrl_bus.rd_addr), 64'd0);
        chk({name, "_num_cls"}, 64'(ctrl_bus.num_cls), 64'd0);
        chk({name, "_count"}, 64'(run_rsp_count), 64'd0);
        chk({name, "_done"}, 64'(run_rsp_done), 64'd0);
        chk({name, "_csum"}, 64'(run_checksum), 64'd0);
        chk({name, "_err_unexp"}, 64'(err_unexpected), 64'd0);
        chk({name, "_err_over"}, 64'(err_overrun), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic vec_t mkv(input e_afu_state st, input t_cci_mdata tag, input logic vld,
                                 input logic [31:0] w0, input logic [31:0] w1, input logic [41:0] addr,
                                 input logic ack, input logic valid, input logic [31:0] count,
                                 input logic done, input logic [31:0] csum, input logic eu,
                                 input logic eo, input logic [31:0] num_out, input logic [41:0] addr_out);
        vec_t v;
        v.st = st; v.tag = tag; v.vld = vld; v.w0 = w0; v.w1 = w1; v.addr = addr;
        v.ack = ack; v.valid = valid; v.count = count; v.done = done;
        v.csum = CSUM_ON ? csum : 32'd0;
        v.eu = eu; v.eo = eo; v.num_out = num_out; v.addr_out = addr_out;
        return v;
    endfunction

    initial begin
        e_afu_state   rst;
        logic [511:0] d;
        t_cci_mdata   tag;
        int           r;
        logic         vld;

        //            state     tag              vld  w0   w1  addr      ack valid cnt done csum eu eo num addr_out
        vecs[0]  = mkv(AFU_CTRL, READ_CTRL_MDATA, 1, 32'd0,             0, 42'h0,    1, 0, 0, 0, 0,  0, 0, 0, 42'h0);
        vecs[1]  = mkv(AFU_CTRL, READ_CTRL_MDATA, 1, CONTROL_START_RUN, 3, 42'h1000, 1, 1, 0, 0, 0,  0, 0, 3, 42'h1000);
        vecs[2]  = mkv(AFU_RUN,  READ_RUN_MDATA,  1, 32'd1,             0, 42'h0,    0, 0, 1, 0, 1,  0, 0, 3, 42'h1000);
        vecs[3]  = mkv(AFU_RUN,  READ_RUN_MDATA,  1, 32'd2,             0, 42'h0,    0, 0, 2, 0, 3,  0, 0, 3, 42'h1000);
        vecs[4]  = mkv(AFU_RUN,  READ_RUN_MDATA,  1, 32'd3,             0, 42'h0,    0, 0, 3, 0, 6,  0, 0, 3, 42'h1000);
        vecs[5]  = mkv(AFU_RUN,  READ_RUN_MDATA,  1, 32'd4,             0, 42'h0,    0, 0, 4, 1, 10, 0, 0, 3, 42'h1000);
        vecs[6]  = mkv(AFU_RUN,  READ_RUN_MDATA,  1, 32'd5,             0, 42'h0,    0, 0, 4, 1, 10, 0, 1, 3, 42'h1000);
        vecs[7]  = mkv(AFU_CTRL, READ_RUN_MDATA,  1, 32'd7,             0, 42'h0,    0, 0, 4, 1, 10, 1, 1, 3, 42'h1000);
        vecs[8]  = mkv(AFU_RUN,  16'h7FFF,        1, 32'd1,             0, 42'h0,    0, 0, 4, 1, 10, 1, 1, 3, 42'h1000);
        vecs[9]  = mkv(AFU_CTRL, 16'h7FFF,        1, CONTROL_START_RUN, 9, 42'h0,    0, 0, 4, 1, 10, 1, 1, 3, 42'h1000);
        vecs[10] = mkv(AFU_IDLE, READ_CTRL_MDATA, 0, 32'd2,             0, 42'h0,    0, 0, 4, 1, 10, 1, 1, 3, 42'h1000);

        reset_n = 1'b0;
        rx_valid = 1'b0;
        afu_state = AFU_IDLE;
        rx_mdata = '0;
        rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_check("reset");

        for (int i = 0; i < 11; i++) begin
            tick(vecs[i].vld, vecs[i].st, vecs[i].tag, line(vecs[i].w0, vecs[i].w1, vecs[i].addr),
                 1'b1, vecs[i], i);
        end
        idle(2);

        // Reset in the middle of a run, then a single-line run
        reset_check("reset2");
        idle(1);
        send(AFU_CTRL, READ_CTRL_MDATA, CONTROL_START_RUN, 5, 42'h2000);
        send(AFU_RUN, READ_RUN_MDATA, 32'hAAAA_0001, 0, 42'h0);
        send(AFU_RUN, READ_RUN_MDATA, 32'h5555_0002, 0, 42'h0);
        idle(3);
        chk("midrun_count", 64'(run_rsp_count), 64'd2);
        chk("midrun_done", 64'(run_rsp_done), 64'd0);
        reset_check("midrun_reset");
        send(AFU_CTRL, READ_CTRL_MDATA, CONTROL_START_RUN, 0, 42'h40);
        send(AFU_RUN, READ_RUN_MDATA, 32'd9, 0, 42'h0);
        idle(3);
        chk("single_done", 64'(run_rsp_done), 64'd1);
        chk("single_count", 64'(run_rsp_count), 64'd1);

        // A control response caught in the pipe by reset must not pulse afterwards
        send(AFU_CTRL, READ_CTRL_MDATA, 32'd5, 2, 42'h80);
        reset_check("pipe_reset");
        idle(4);

        // START while a run is in flight, then randomized traffic
        send(AFU_CTRL, READ_CTRL_MDATA, CONTROL_START_RUN, 7, 42'h0);
        send(AFU_RUN, READ_RUN_MDATA, 32'd3, 0, 42'h0);
        send(AFU_CTRL, READ_CTRL_MDATA, CONTROL_START_RUN, 1, 42'h0);
        send(AFU_RUN, READ_RUN_MDATA, 32'd4, 32'd8, 42'h0);
        idle(2);

        rst = AFU_CTRL;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 5) == 0) rst = e_afu_state'($urandom_range(0, 3));
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            r = $urandom_range(0, 2);
            d[31:0] = (r == 0) ? 32'd0 : (r == 1) ? CONTROL_START_RUN : 32'($urandom);
            d[63:32] = 32'($urandom_range(0, 5));
            r = $urandom_range(0, 7);
            tag = (r < 3) ? READ_CTRL_MDATA : (r < 7) ? READ_RUN_MDATA : t_cci_mdata'($urandom);
            vld = ($urandom_range(0, 4) != 0);
            tick(vld, rst, tag, d, 1'b0, nov, 0);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
